vector_reg_stream_slice: RTL and testbench

Vector register of LENGTH scalars with four access paths: full-vector parallel load, indexed single-scalar write, valid/ready streaming fill (one scalar per handshake), and valid/ready streaming drain. It also provides a combinational indexed slice read. It sits between the scalar-serial datapaths and the vector/matrix units of the classifier, so vectors can be assembled or emitted element by element without external counters.

---
 rtl/vector_reg_pkg.sv | 10 +
 rtl/vreg_index_counter.sv | 29 ++
 rtl/vector_reg_stream_slice.sv | 141 ++++++++++++++
 tb/tb_vector_reg_stream_slice.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_reg_pkg.sv
// rtl/vector_reg_pkg.sv - shared state type and index-width helper for the vector register
package vector_reg_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} vreg_state_t;

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vreg_index_counter.sv
// rtl/vreg_index_counter.sv - element counter that wraps at LENGTH-1 and flags the last element
module vreg_index_counter
  import vector_reg_pkg::*;
#(
  parameter int LENGTH = 5,
  parameter int WIDTH  = index_width(LENGTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  assign last = (count == WIDTH'(LENGTH - 1));

  // clear beats inc so an abort on a handshake cycle still lands on zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vector_reg_stream_slice.sv
// rtl/vector_reg_stream_slice.sv - vector register with parallel load, indexed write,
// streaming fill/drain and combinational slice read
module vector_reg_stream_slice
  import vector_reg_pkg::*;
#(
  parameter  int SCALAR_BITS = 32,
  parameter  int LENGTH      = 5,
  localparam int INDEX_WIDTH = index_width(LENGTH),
  localparam int SIZE_BITS   = LENGTH * SCALAR_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [SIZE_BITS-1:0]   in,
  output logic [SIZE_BITS-1:0]   out,
  input  logic                   write_en,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic [SCALAR_BITS-1:0] write_data,
  input  logic [INDEX_WIDTH-1:0] read_index,
  output logic [SCALAR_BITS-1:0] slice_out,
  input  logic                   fill_start,
  input  logic                   drain_start,
  input  logic                   abort,
  input  logic                   s_valid,
  input  logic [SCALAR_BITS-1:0] s_data,
  output logic                   s_ready,
  output logic                   m_valid,
  output logic [SCALAR_BITS-1:0] m_data,
  input  logic                   m_ready,
  output logic                   busy,
  output logic                   fill_done,
  output logic                   drain_done
);

  vreg_state_t            state_q, state_d;
  logic [SIZE_BITS-1:0]   data_q, data_d;
  logic [INDEX_WIDTH-1:0] count;
  logic                   last;
  logic                   cnt_clear, cnt_inc;
  logic                   fill_done_d, drain_done_d;
  logic                   fill_hs, drain_hs;

  vreg_index_counter #(
    .LENGTH (LENGTH),
    .WIDTH  (INDEX_WIDTH)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (count),
    .last  (last)
  );

  assign s_ready  = (state_q == FILL);
  assign m_valid  = (state_q == DRAIN);
  assign busy     = (state_q != IDLE);
  assign fill_hs  = s_ready & s_valid;
  assign drain_hs = m_valid & m_ready;
  assign out      = data_q;
  assign m_data   = data_q[32'(count) * SCALAR_BITS +: SCALAR_BITS];

  always_comb begin
    slice_out = '0;
    if (32'(read_index) < LENGTH) begin
      slice_out = data_q[32'(read_index) * SCALAR_BITS +: SCALAR_BITS];
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    fill_done_d  = 1'b0;
    drain_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          data_d = in;
        end
        // applied after the load so the scalar overrides that element of in
        if (write_en && (32'(write_index) < LENGTH)) begin
          data_d[32'(write_index) * SCALAR_BITS +: SCALAR_BITS] = write_data;
        end
        if (fill_start) begin
          state_d   = FILL;
          cnt_clear = 1'b1;
        end else if (drain_start) begin
          state_d   = DRAIN;
          cnt_clear = 1'b1;
        end
      end
      FILL: begin
        if (fill_hs) begin
          data_d[32'(count) * SCALAR_BITS +: SCALAR_BITS] = s_data;
          cnt_inc = 1'b1;
          if (last) begin
            state_d     = IDLE;
            fill_done_d = !abort;
          end
        end
        if (abort) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_hs) begin
          cnt_inc = 1'b1;
          if (last) begin
            state_d      = IDLE;
            drain_done_d = !abort;
          end
        end
        if (abort) begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      fill_done  <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      fill_done  <= fill_done_d;
      drain_done <= drain_done_d;
    end
  end

endmodule

// File: tb/tb_vector_reg_stream_slice.sv
// tb/tb_vector_reg_stream_slice.sv - randomized bench with an element-array reference model
module tb_vector_reg_stream_slice;

  localparam int SB  = 32;
  localparam int LEN = 5;
  localparam int IW  = 3;
  localparam int SZ  = LEN * SB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [SZ-1:0] in_v = '0;
  logic [SZ-1:0] out_v;
  logic          write_en = 1'b0;
  logic [IW-1:0] write_index = '0;
  logic [SB-1:0] write_data = '0;
  logic [IW-1:0] read_index = '0;
  logic [SB-1:0] slice_out;
  logic          fill_start = 1'b0;
  logic          drain_start = 1'b0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic [SB-1:0] s_data = '0;
  logic          s_ready;
  logic          m_valid;
  logic [SB-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          fill_done;
  logic          drain_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  vector_reg_stream_slice #(.SCALAR_BITS(SB), .LENGTH(LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .in          (in_v),
    .out         (out_v),
    .write_en    (write_en),
    .write_index (write_index),
    .write_data  (write_data),
    .read_index  (read_index),
    .slice_out   (slice_out),
    .fill_start  (fill_start),
    .drain_start (drain_start),
    .abort       (abort),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .busy        (busy),
    .fill_done   (fill_done),
    .drain_done  (drain_done)
  );

  task automatic chk(input string name, input logic [SZ-1:0] got, input logic [SZ-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: element array, mode 0=idle 1=fill 2=drain, position in the stream
  logic [SB-1:0] mem [LEN];
  int  mode;
  int  pos;
  bit  e_fd, e_dd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LEN; i++) mem[i] = '0;
      mode = 0; pos = 0; e_fd = 0; e_dd = 0;
    end else begin
      e_fd = 0; e_dd = 0;
      if (mode == 0) begin
        if (load) for (int i = 0; i < LEN; i++) mem[i] = in_v[i*SB +: SB];
        if (write_en && int'(write_index) < LEN) mem[write_index] = write_data;
        if (fill_start) begin mode = 1; pos = 0; end
        else if (drain_start) begin mode = 2; pos = 0; end
      end else begin
        if ((mode == 1 && s_valid) || (mode == 2 && m_ready)) begin
          if (mode == 1) mem[pos] = s_data;
          if (pos == LEN - 1) begin
            if (!abort) begin
              if (mode == 1) e_fd = 1; else e_dd = 1;
            end
            mode = 0; pos = 0;
          end else begin
            pos++;
          end
        end
        if (abort) begin mode = 0; pos = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      logic [SZ-1:0] exp_out;
      for (int i = 0; i < LEN; i++) exp_out[i*SB +: SB] = mem[i];
      chk("model_out", out_v, exp_out);
      chk("model_slice", SZ'(slice_out), (int'(read_index) < LEN) ? SZ'(mem[read_index]) : '0);
      chk("model_s_ready", SZ'(s_ready), SZ'(mode == 1));
      chk("model_m_valid", SZ'(m_valid), SZ'(mode == 2));
      chk("model_busy", SZ'(busy), SZ'(mode != 0));
      chk("model_fill_done", SZ'(fill_done), SZ'(e_fd));
      chk("model_drain_done", SZ'(drain_done), SZ'(e_dd));
      if (mode == 2) chk("model_m_data", SZ'(m_data), SZ'(mem[pos]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 0; write_en = 0; fill_start = 0; drain_start = 0;
    abort = 0; s_valid = 0; m_ready = 0;
  endtask

  task automatic check_element(input int idx, input logic [SB-1:0] exp, input string name);
    read_index = IW'(idx);
    tick();
    chk(name, SZ'(slice_out), SZ'(exp));
  endtask

  initial begin
    int fill_vals [6] = '{10, 20, 0, 30, 40, 50};
    int fill_vld  [6] = '{1, 1, 0, 1, 1, 1};
    int drain_pat [7] = '{1, 0, 1, 1, 0, 1, 1};
    int done_cnt;
    int done_at;
    logic [SB-1:0] drained [$];
    logic [SB-1:0] prev;

    #12;
    chk("reset_out", out_v, '0);
    chk("reset_s_ready", SZ'(s_ready), '0);
    chk("reset_m_valid", SZ'(m_valid), '0);
    chk("reset_busy", SZ'(busy), '0);
    tick();
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // parallel load of five distinct scalars
    for (int i = 0; i < LEN; i++) in_v[i*SB +: SB] = 32'h1111_0000 + i;
    load = 1;
    tick();
    load = 0;
    chk("load_out", out_v, {32'h11110004, 32'h11110003, 32'h11110002, 32'h11110001, 32'h11110000});
    check_element(3, 32'h11110003, "slice_idx3");
    check_element(7, 32'h0, "slice_idx7");

    // streaming fill with a gap after the second element
    fill_start = 1;
    tick();
    fill_start = 0;
    done_cnt = 0; done_at = -1;
    for (int k = 0; k < 6; k++) begin
      s_valid = fill_vld[k][0];
      s_data  = SB'(fill_vals[k]);
      tick();
      if (fill_done) begin done_cnt++; if (done_at < 0) done_at = k; end
    end
    s_valid = 0;
    tick();
    if (fill_done) done_cnt++;
    chk("fill_done_cycle", SZ'(done_at), SZ'(5));
    chk("fill_done_once", SZ'(done_cnt), SZ'(1));
    for (int i = 0; i < LEN; i++) check_element(i, SB'(10 * (i + 1)), "fill_readback");

    // drain with m_ready toggling
    drain_start = 1;
    tick();
    drain_start = 0;
    done_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      m_ready = drain_pat[k][0];
      prev = m_data;
      if (drain_pat[k] == 1) drained.push_back(m_data);
      tick();
      if (drain_pat[k] == 0) chk("drain_hold", SZ'(m_data), SZ'(prev));
      if (drain_done) done_cnt++;
    end
    m_ready = 0;
    chk("drain_done_last", SZ'(drain_done), SZ'(1));
    chk("drain_busy_fall", SZ'(busy), '0);
    tick();
    if (drain_done) done_cnt++;
    chk("drain_done_once", SZ'(done_cnt), SZ'(1));
    chk("drain_count", SZ'(drained.size()), SZ'(5));
    for (int i = 0; i < drained.size(); i++) chk("drain_seq", SZ'(drained[i]), SZ'(10 * (i + 1)));

    // load + write + both starts in one IDLE cycle
    for (int i = 0; i < LEN; i++) in_v[i*SB +: SB] = 32'hB0 + i;
    load = 1; write_en = 1; write_index = 2; write_data = 32'hAA;
    fill_start = 1; drain_start = 1;
    tick();
    idle_inputs();
    chk("combo_s_ready", SZ'(s_ready), SZ'(1));
    chk("combo_m_valid", SZ'(m_valid), '0);
    chk("combo_out", out_v, {32'hB4, 32'hB3, 32'hAA, 32'hB1, 32'hB0});

    // three fill handshakes, abort on the third; write_en must be ignored
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1; s_data = 32'h100 + k;
      write_en = 1; write_index = 4; write_data = 32'hDEAD;
      abort = (k == 2);
      tick();
      if (fill_done) done_cnt++;
    end
    idle_inputs();
    chk("abort_busy", SZ'(busy), '0);
    tick();
    if (fill_done) done_cnt++;
    chk("abort_no_done", SZ'(done_cnt), '0);
    chk("abort_out", out_v, {32'hB4, 32'hB3, 32'h102, 32'h101, 32'h100});

    // asynchronous reset in the middle of a drain
    drain_start = 1;
    tick();
    drain_start = 0;
    m_ready = 1;
    tick();
    m_ready = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out", out_v, '0);
    chk("async_m_valid", SZ'(m_valid), '0);
    chk("async_busy", SZ'(busy), '0);
    chk("async_m_data", SZ'(m_data), '0);
    tick();
    rst_n = 1'b1;

    // randomized traffic checked every cycle by the model
    for (int n = 0; n < 4000; n++) begin
      load        = ($urandom % 8) == 0;
      for (int i = 0; i < LEN; i++) in_v[i*SB +: SB] = $urandom;
      write_en    = ($urandom % 4) == 0;
      write_index = IW'($urandom % 8);
      write_data  = $urandom;
      read_index  = IW'($urandom % 8);
      fill_start  = ($urandom % 10) == 0;
      drain_start = ($urandom % 10) == 0;
      abort       = ($urandom % 25) == 0;
      s_valid     = ($urandom % 3) != 0;
      s_data      = $urandom;
      m_ready     = ($urandom % 3) != 0;
      if (n == 2000) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
